am_envelope_modulator: RTL

- Downstream consumer of the NCO carrier. Takes one NCO output (cos) as the RF carrier and accepts audio samples over a valid/ready handshake at a fixed sample rate.
- Forms the AM envelope (DC offset plus depth-scaled audio) and multiplies it with the carrier in a pipeline.
- Quantises the result with a first-order sigma-delta loop to drive the single-bit RF output pin.

---
 rtl/am_pkg.sv | 10 +
 rtl/sigma_delta_1st.sv | 43 ++++
 rtl/am_envelope_modulator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/am_pkg.sv
// Shared constants for the AM envelope modulator and its sigma-delta output stage.
package am_pkg;

    localparam int unsigned ENV_OFFSET     = 32768;
    localparam int          SD_FB_POS      = 32767;
    localparam int          SD_FB_NEG      = -32768;
    localparam int unsigned ACC_BITS       = 18;
    localparam int unsigned DEF_SAMPLE_DIV = 2268;

endpackage

// File: rtl/sigma_delta_1st.sv
// First-order sigma-delta quantiser: turns a signed sample stream into a 1-bit
// stream whose +32767/-32768 mean tracks the input mean.
module sigma_delta_1st
    import am_pkg::*;
#(
    parameter int unsigned BITS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [BITS-1:0] y,
    output logic            rf_out
);

    localparam logic signed [ACC_BITS-1:0] FB_POS = ACC_BITS'(SD_FB_POS);
    localparam logic signed [ACC_BITS-1:0] FB_NEG = ACC_BITS'(SD_FB_NEG);

    logic signed [ACC_BITS-1:0] acc_q, acc_d;
    logic signed [ACC_BITS-1:0] acc_next, y_ext, fb;
    logic                       rf_q, rf_d;

    always_comb begin
        y_ext    = ACC_BITS'($signed(y));
        fb       = rf_q ? FB_POS : FB_NEG;
        acc_next = acc_q + y_ext - fb;
        // Disabled: loop is parked at zero so re-enable starts from a clean state.
        acc_d    = enable ? acc_next : '0;
        rf_d     = enable & ~acc_next[ACC_BITS-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            rf_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            rf_q  <= rf_d;
        end
    end

    assign rf_out = rf_q;

endmodule

// File: rtl/am_envelope_modulator.sv
// AM modulator: paced audio intake, envelope = offset + depth-scaled audio,
// envelope x carrier pipeline, then a 1-bit sigma-delta RF output.
module am_envelope_modulator
    import am_pkg::*;
#(
    parameter int unsigned BITS       = 16,
    parameter int unsigned DEPTH_BITS = 8,
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic                  CLK,
    input  logic                  RSTb,
    input  logic [BITS-1:0]       carrier,
    input  logic [BITS-1:0]       audio_data,
    input  logic                  audio_valid,
    output logic                  audio_ready,
    input  logic [DEPTH_BITS-1:0] mod_depth,
    input  logic                  enable,
    input  logic                  underrun_clr,
    output logic                  underrun,
    output logic                  rf_out
);

    localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned ENV_W  = BITS + 1;
    localparam int unsigned ENV_X  = ENV_W + 1;
    localparam int unsigned PROD_W = BITS + ENV_W + 1;
    localparam int unsigned SCL_W  = BITS + DEPTH_BITS + 1;

    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic signed [ENV_W:0]   ENV_OFF  = ENV_X'(ENV_OFFSET);

    logic                     pend_q, pend_d;
    logic [BITS-1:0]          pdata_q, pdata_d;
    logic [BITS-1:0]          active_q, active_d;
    logic                     load_q, load_d;
    logic [ENV_W-1:0]         env_q, env_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic                     unr_q, unr_d;
    logic signed [PROD_W-1:0] p_q, p_d;
    logic [BITS-1:0]          y_q, y_d;

    logic                     tick, xfer, unr_set;
    logic signed [SCL_W-1:0]  scaled_full;
    logic signed [ENV_W:0]    env_sum;
    logic                     unused_bits;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        xfer    = audio_valid & ~pend_q;
        div_d   = tick ? '0 : div_q + DIV_W'(1);

        pend_d   = pend_q;
        pdata_d  = pdata_q;
        active_d = active_q;
        load_d   = 1'b0;
        unr_set  = 1'b0;

        // An empty pending slot on a tick lets a same-cycle transfer bypass straight to active.
        if (tick) begin
            if (pend_q) begin
                active_d = pdata_q;
                pend_d   = 1'b0;
                load_d   = 1'b1;
            end else if (xfer) begin
                active_d = audio_data;
                load_d   = 1'b1;
            end else begin
                unr_set  = 1'b1;
            end
        end else if (xfer) begin
            pend_d  = 1'b1;
            pdata_d = audio_data;
        end

        unr_d = unr_set | (unr_q & ~underrun_clr);

        scaled_full = SCL_W'($signed(active_q)) * SCL_W'($signed({1'b0, mod_depth}));
        env_sum     = ENV_OFF + ENV_X'($signed(scaled_full[SCL_W-1:DEPTH_BITS]));
        env_d       = load_q ? env_sum[ENV_W-1:0] : env_q;

        p_d = PROD_W'($signed(carrier)) * PROD_W'($signed({1'b0, env_q}));
        y_d = p_q[ENV_W +: BITS];
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            pend_q   <= 1'b0;
            pdata_q  <= '0;
            active_q <= '0;
            load_q   <= 1'b0;
            env_q    <= ENV_W'(ENV_OFFSET);
            div_q    <= '0;
            unr_q    <= 1'b0;
            p_q      <= '0;
            y_q      <= '0;
        end else begin
            pend_q   <= pend_d;
            pdata_q  <= pdata_d;
            active_q <= active_d;
            load_q   <= load_d;
            env_q    <= env_d;
            div_q    <= div_d;
            unr_q    <= unr_d;
            p_q      <= p_d;
            y_q      <= y_d;
        end
    end

    sigma_delta_1st #(
        .BITS (BITS)
    ) u_sd (
        .clk    (CLK),
        .rst_n  (RSTb),
        .enable (enable),
        .y      (y_q),
        .rf_out (rf_out)
    );

    assign audio_ready = ~pend_q;
    assign underrun    = unr_q;

    assign unused_bits = ^{p_q[ENV_W-1:0], p_q[PROD_W-1],
                           scaled_full[DEPTH_BITS-1:0], env_sum[ENV_W]};

endmodule
